// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: arbitrates MEM stage and debug port onto a single-port big-endian word memory,
// with read wait states and read-modify-write for sub-word stores. Macro: DMEM_MISALIGN_TRAP_EN.
module dmem_access_ctrl #(
  parameter int unsigned RD_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_unsigned,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic        cpu_stall,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic [31:0] dbg_rdata,
  output logic        dbg_done,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writedata,
  output logic        mem_writeenable,
  output logic        mem_MemRead,
  input  logic [31:0] mem_data
);

  localparam int unsigned CntW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(RD_LAT - 1);

  localparam logic [1:0] SzByte = 2'b00;
  localparam logic [1:0] SzHalf = 2'b01;
  localparam logic [1:0] SzWord = 2'b10;

`ifdef DMEM_MISALIGN_TRAP_EN
  typedef enum logic [2:0] {StIdle, StWr, StRd, StMrg, StResp, StErr} state_e;
`else
  typedef enum logic [2:0] {StIdle, StWr, StRd, StMrg, StResp} state_e;
`endif

  state_e state_q, state_d;

  logic            owner_q, owner_d;       // 1 = debug port owns the access
  logic            last_dbg_q, last_dbg_d;
  logic            we_q, we_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     maddr_q, maddr_d;
  logic [31:0]     rbuf_q, rbuf_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic        any_req;
  logic        grant_dbg;
  logic        sel_we;
  logic [1:0]  sel_size;
  logic        sel_uns;
  logic [31:0] sel_raw;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        go_err;
  logic        rd_last;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic [31:0] merged;
  logic        we_raw;
  logic        rd_raw;

  assign rd_last = (cnt_q == CntLast);

  // Arbitration and request decode of the port that would be granted this cycle.
  always_comb begin
    any_req   = cpu_req | dbg_req;
    grant_dbg = (cpu_req & dbg_req) ? ~last_dbg_q : dbg_req;
    if (grant_dbg) begin
      sel_we    = dbg_we;
      sel_size  = SzWord;
      sel_uns   = 1'b0;
      sel_raw   = dbg_addr;
      sel_wdata = dbg_wdata;
    end else begin
      sel_we    = cpu_we;
      sel_size  = cpu_size[1] ? SzWord : cpu_size;
      sel_uns   = cpu_unsigned;
      sel_raw   = cpu_addr;
      sel_wdata = cpu_wdata;
    end
    case (sel_size)
      SzHalf:  sel_addr = {sel_raw[31:1], 1'b0};
      SzWord:  sel_addr = {sel_raw[31:2], 2'b00};
      default: sel_addr = sel_raw;
    endcase
`ifdef DMEM_MISALIGN_TRAP_EN
    go_err = ~grant_dbg & (((sel_size == SzHalf) & sel_raw[0]) |
                           ((sel_size == SzWord) & (|sel_raw[1:0])));
`else
    go_err = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (any_req) begin
          if (sel_we && (sel_size == SzWord)) begin
            state_d = StWr;
          end else begin
            state_d = StRd;
          end
`ifdef DMEM_MISALIGN_TRAP_EN
          if (go_err) begin
            state_d = StErr;
          end
`endif
        end
      end
      StWr:   state_d = StResp;
      StRd: begin
        if (rd_last) begin
          state_d = we_q ? StMrg : StResp;
        end
      end
      StMrg:  state_d = StResp;
      StResp: state_d = StIdle;
`ifdef DMEM_MISALIGN_TRAP_EN
      StErr:  state_d = StIdle;
`endif
      default: state_d = StIdle;
    endcase
  end

  // Request latches, read counter and read buffer.
  always_comb begin
    owner_d    = owner_q;
    last_dbg_d = last_dbg_q;
    we_d       = we_q;
    size_d     = size_q;
    uns_d      = uns_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    maddr_d    = maddr_q;
    rbuf_d     = rbuf_q;
    cnt_d      = cnt_q;
    if ((state_q == StIdle) && any_req) begin
      owner_d = grant_dbg;
      we_d    = sel_we;
      size_d  = sel_size;
      uns_d   = sel_uns;
      addr_d  = sel_addr;
      wdata_d = sel_wdata;
      cnt_d   = '0;
      // The pointer only moves on contested grants, so successive ties alternate.
      if (cpu_req && dbg_req) begin
        last_dbg_d = grant_dbg;
      end
      if (!go_err) begin
        maddr_d = {sel_addr[31:2], 2'b00};
      end
    end
    if (state_q == StRd) begin
      cnt_d = cnt_q + CntW'(1);
      if (rd_last) begin
        rbuf_d = mem_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q    <= 1'b0;
      last_dbg_q <= 1'b1;
      we_q       <= 1'b0;
      size_q     <= SzWord;
      uns_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      maddr_q    <= '0;
      rbuf_q     <= '0;
      cnt_q      <= '0;
    end else begin
      owner_q    <= owner_d;
      last_dbg_q <= last_dbg_d;
      we_q       <= we_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      maddr_q    <= maddr_d;
      rbuf_q     <= rbuf_d;
      cnt_q      <= cnt_d;
    end
  end

  // Big-endian lane select and extension for loads.
  always_comb begin
    case (addr_q[1:0])
      2'd0:    ld_byte = rbuf_q[31:24];
      2'd1:    ld_byte = rbuf_q[23:16];
      2'd2:    ld_byte = rbuf_q[15:8];
      default: ld_byte = rbuf_q[7:0];
    endcase
    ld_half = addr_q[1] ? rbuf_q[15:0] : rbuf_q[31:16];
    case (size_q)
      SzByte:  ld_ext = {{24{~uns_q & ld_byte[7]}}, ld_byte};
      SzHalf:  ld_ext = {{16{~uns_q & ld_half[15]}}, ld_half};
      default: ld_ext = rbuf_q;
    endcase
  end

  // Sub-word store merge into the word just read back.
  always_comb begin
    merged = rbuf_q;
    if (size_q == SzByte) begin
      case (addr_q[1:0])
        2'd0:    merged[31:24] = wdata_q[7:0];
        2'd1:    merged[23:16] = wdata_q[7:0];
        2'd2:    merged[15:8]  = wdata_q[7:0];
        default: merged[7:0]   = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merged[15:0] = wdata_q[15:0];
    end else begin
      merged[31:16] = wdata_q[15:0];
    end
  end

  always_comb begin
    cpu_done      = 1'b0;
    cpu_err       = 1'b0;
    cpu_rdata     = '0;
    dbg_done      = 1'b0;
    dbg_rdata     = '0;
    we_raw        = 1'b0;
    rd_raw        = 1'b0;
    mem_writedata = wdata_q;
    case (state_q)
      StWr:  we_raw = 1'b1;
      StRd:  rd_raw = 1'b1;
      StMrg: begin
        we_raw        = 1'b1;
        mem_writedata = merged;
      end
      StResp: begin
        if (owner_q) begin
          dbg_done  = 1'b1;
          dbg_rdata = rbuf_q;
        end else begin
          cpu_done  = 1'b1;
          cpu_rdata = ld_ext;
        end
      end
`ifdef DMEM_MISALIGN_TRAP_EN
      StErr: begin
        if (owner_q) begin
          dbg_done = 1'b1;
        end else begin
          cpu_done = 1'b1;
          cpu_err  = 1'b1;
        end
      end
`endif
      default: ;
    endcase
    // Reset masks the strobes immediately so an aborted access never writes.
    mem_writeenable = we_raw & ~reset;
    mem_MemRead     = rd_raw & ~reset;
  end

  assign mem_address = maddr_q;
  assign cpu_stall   = cpu_req & ~cpu_done;

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Sequencing and arbitration controller in front of the single-port, byte-addressed, big-endian data memory of the pipelined RISC-V core. Shares the memory between the MEM stage and a debug/loader port using round-robin arbitration. Inserts read wait cycles for the slow memory read path and performs read-modify-write for byte and halfword stores, because the memory only writes whole words. Returns sign- or zero-extended load data and stalls the pipeline until each access completes.

## Interface
- RD_LAT, 2: cycles `mem_MemRead`/address are held before read data is captured (≥1)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- cpu_req  in  1  MEM-stage request, held until `cpu_done`
- cpu_we  in  1  1 = store, 0 = load
- cpu_size  in  2  00 byte, 01 half, 10 word (11 treated as word)
- cpu_unsigned  in  1  zero-extend loads (lbu/lhu)
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  store data, right-justified
- cpu_rdata  out  32  extended load data, valid while `cpu_done`
- cpu_done  out  1  one-cycle completion pulse
- cpu_err  out  1  misaligned access, valid with `cpu_done`
- cpu_stall  out  1  `cpu_req & ~cpu_done`
- dbg_req, dbg_we  in  1  debug word request and direction, held until `dbg_done`
- dbg_addr, dbg_wdata  in  32  debug word address and data
- dbg_rdata  out  32  debug read word, valid while `dbg_done`
- dbg_done  out  1  one-cycle completion pulse
- mem_address  out  32  to memory `address`
- mem_writedata  out  32  to memory `writedata`
- mem_writeenable  out  1  to memory `writeenable`
- mem_MemRead  out  1  to memory `MemRead`
- mem_data  in  32  from memory `data`

## Operation
- States: IDLE, WR, RD, MRG, RESP, ERR.
- IDLE:
  - Grant on the clock edge when any request is high; latch owner, address, data, size and sign.
  - Next state: word store → WR; load or sub-word store → RD; misaligned access → ERR.
- Arbitration:
  - Round-robin with a one-bit last-owner pointer.
  - Both requesting: grant the port not served last.
  - Pointer resets so the CPU wins the first tie.
- WR: `mem_writeenable`=1, address and data from the latches → RESP.
- RD:
  - `mem_MemRead`=1; word-aligned address (addr[1:0] cleared).
  - Counter runs RD_LAT cycles; on the last cycle's edge `mem_data` is captured into the read buffer.
  - Next state: load → RESP; sub-word store → MRG.
- MRG: write the read buffer with the target lane(s) replaced → RESP.
  - Byte lanes, big-endian: addr[1:0]=0 → bits [31:24], 3 → bits [7:0].
  - Halfword: addr[1]=0 → [31:16], 1 → [15:0].
- RESP: pulse the owner's `done` for one cycle.
  - Loads: select the lane, then sign- or zero-extend to 32 bits.
  - Debug port is always word-only.
  - Next state: IDLE.
- ERR: owner's `done` and `cpu_err` pulse together, no memory strobe → IDLE.
- A request still high in the IDLE cycle after RESP is a new request. Requesters drop `req` on the edge that ends their `done` cycle.
- Memory strobes are 0 in every state not listed above. When idle, `mem_address` holds its last value.

## Timing
- Reset values: state IDLE; `cpu_done`, `cpu_err`, `dbg_done`, `mem_writeenable`, `mem_MemRead` = 0; `cpu_rdata`, `dbg_rdata`, `mem_address`, `mem_writedata` = 0; pointer favours CPU.
- Reset gates `mem_writeenable` and `mem_MemRead` combinationally, so no write happens in any cycle where `reset`=1.
- Reset mid-operation aborts the access, with no `done` pulse.
- Latency in cycles from the grant edge to the `done` cycle:
  - word store: 2
  - load: RD_LAT+1
  - sub-word store: RD_LAT+2
  - error: 1
- Exactly one memory write per store. Sub-word stores issue exactly one read burst first.
- `cpu_stall` is combinational and drops in the `done` cycle.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined:
  - halfword with addr[0]=1, or word with addr[1:0]≠0 → ERR state, `cpu_err` pulse, no memory access.
- `DMEM_MISALIGN_TRAP_EN` undefined:
  - offending low bits are forced to 0 (half: bit 0; word: bits 1:0) and the access proceeds normally.
  - ERR state is absent and `cpu_err` is tied to 0.

## Test plan
- Memory word 0x10 = 0x11223384, RD_LAT=2, CPU lw 0x10 → `cpu_done` 3 cycles after grant, `cpu_rdata`=0x11223384; `mem_MemRead` high exactly 2 cycles.
- Same word: lb 0x13 → 0xFFFFFF84; lbu 0x13 → 0x00000084; lh 0x12 → 0x00003384; lh 0x10 → 0x00001122.
- sb 0x11 with data 0x000000AB → one read, then one write of 0x11AB3384 to 0x10; `cpu_done` at cycle RD_LAT+2; a following lw 0x10 returns 0x11AB3384.
- `cpu_req` and `dbg_req` rise together after reset:
  - CPU served first, then debug.
  - Next simultaneous pair: debug first.
  - `cpu_stall` stays high while debug is served.
- lw 0x12 with macro → `cpu_done`+`cpu_err` 1 cycle after grant, no strobes. Without macro → reads word 0x10, `cpu_err`=0.
- `reset` asserted during the MRG cycle of sb 0x11 → no write, memory word stays 0x11223384, all outputs 0 next cycle, no `done`.
